count_sequencer: RTL and testbench
==================================

Name: count_sequencer

Overview:
Controller that sequences the 8-bit counter datapath driving the dedicated outputs. It takes push-button style commands (start/stop/step/load) and quasi-static configuration from the input pins. It generates the counter's enable, direction and load strobes with a programmable prescaler, and detects terminal count for one-shot or auto-reload operation. It sits between the top-level pin wrapper and the counter instance; the counter's current value is fed back to it.

Parameters:
WIDTH, 8, counter width.
PRESCALE_W, 8, prescaler width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  asynchronous pin; rising edge = start/resume
stop  in  1  asynchronous pin; rising edge = pause/abort
step  in  1  asynchronous pin; rising edge = single count
load  in  1  asynchronous pin; rising edge = load load_value
dir  in  1  1 = up, 0 = down (quasi-static)
auto_reload  in  1  1 = wrap at terminal, 0 = stop at terminal (quasi-static)
load_value  in  WIDTH  value applied on load command
limit  in  WIDTH  terminal value when counting up; restart value when counting down
prescale  in  PRESCALE_W  tick period minus 1
cnt_value  in  WIDTH  current counter value (feedback)
cnt_en  out  1  counter increments/decrements at next edge
cnt_up  out  1  direction to counter
cnt_load  out  1  counter loads cnt_load_val at next edge
cnt_load_val  out  WIDTH  load data
state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
busy  out  1  state==RUN
done  out  1  state==DONE
wrap  out  1  registered 1-cycle pulse on auto-reload

Behaviour:
- Reset: async, immediate. state=IDLE, prescaler=0, sync/edge regs=0, wrap=0. Hence cnt_en=0, cnt_load=0, done=0, busy=0. cnt_up=dir.
- Pin inputs: 2-flop synchroniser plus registered previous value. Edge pulse = sync & ~prev, high for exactly 1 cycle.
- Edge timing: if a pin is first sampled high at edge N, the command takes effect (state/prescaler update) at edge N+2.
- Strobes: cnt_en, cnt_load and cnt_load_val are combinational from registered state, prescaler, edge pulses, config and cnt_value. There is no combinational path from pins. The counter acts on them at the next edge, so the feedback is always current.
- Restart value R: 0 if dir=1, limit if dir=0.
- Terminal condition T: (dir=1 and cnt_value==limit) or (dir=0 and cnt_value==0).
- Tick: state==RUN and prescaler==prescale. Prescaler counts 0..prescale in RUN, clears on tick. prescale=0 gives a tick every cycle. Prescaler is held in PAUSE and cleared on entering RUN from IDLE/DONE.
- Advance event (tick in RUN, or step edge in IDLE/PAUSE):
  - not T: cnt_en=1.
  - T and auto_reload=1: cnt_load=1, cnt_load_val=R, cnt_en=0, wrap=1 next cycle, state unchanged.
  - T and auto_reload=0: cnt_en=0, state→DONE.
- Command priority per cycle: load > stop > start > step > tick. A lower-priority event in the same cycle is dropped; tick is suppressed.
- load edge (any state): cnt_load=1, cnt_load_val=load_value, state→IDLE, prescaler←0.
- stop edge: RUN→PAUSE (prescaler held); PAUSE→IDLE (prescaler←0); no effect in IDLE/DONE.
- start edge: IDLE/PAUSE→RUN; DONE→RUN with cnt_load=1, cnt_load_val=R that cycle; ignored in RUN.
- step edge: ignored in RUN/DONE.
- Config changes while RUN take effect at the next evaluation; no glitch filtering.
- Reset mid-operation: strobes drop immediately. After release, state is IDLE and a new start edge is required.

Decomposition:
- Package count_seq_pkg: state enum (IDLE/RUN/PAUSE/DONE, 2-bit encodings above) and default parameter constants.
- Sub-module edge_sync: 2-flop synchroniser plus rising-edge detect, async active-high reset. Instantiated 4× (start, stop, step, load).

Test Plan:
- Reset: hold rst=1 with pins toggling → state=0, cnt_en=0, cnt_load=0, done=0, wrap=0. Assert rst between edges mid-RUN → strobes 0 before the next edge.
- Bench includes a behavioural counter model. dir=1, limit=5, prescale=3, auto_reload=0, start from value 0 → cnt_en high 1 cycle in every 4. Count goes 0..5, then state=3, done=1, no further cnt_en.
- dir=1, limit=2, prescale=0, auto_reload=1 → count sequence 0,1,2,0,1,2. wrap pulses once per 3 cycles. state stays 1.
- dir=0, load_value=3, load then 4 step edges with auto_reload=0 → count 3,2,1,0. The 4th step gives state=3 and no cnt_en.
- In RUN, stop and start rise in the same cycle → state=2 with prescaler held. Next stop → state=0. Start → state=1.
- load pulse in RUN coinciding with a tick → cnt_load=1, cnt_load_val=load_value, cnt_en=0, state=0. Start from DONE → cnt_load with R and state=1.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared types and default sizing for the counter sequencer.
package count_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PRESCALE_W = 8;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous pin followed by a rising-edge detector.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic pulse
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/count_sequencer.sv
// Sequences an external counter: command decode, prescaled ticks, terminal-count
// handling for one-shot or auto-reload operation.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic                  load,
  input  logic                  dir,
  input  logic                  auto_reload,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      cnt_value,
  output logic                  cnt_en,
  output logic                  cnt_up,
  output logic                  cnt_load,
  output logic [WIDTH-1:0]      cnt_load_val,
  output logic [1:0]            state,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap
);

  logic start_p, stop_p, step_p, load_p;

  edge_sync u_sync_start (.clk(clk), .rst(rst), .pin(start), .pulse(start_p));
  edge_sync u_sync_stop  (.clk(clk), .rst(rst), .pin(stop),  .pulse(stop_p));
  edge_sync u_sync_step  (.clk(clk), .rst(rst), .pin(step),  .pulse(step_p));
  edge_sync u_sync_load  (.clk(clk), .rst(rst), .pin(load),  .pulse(load_p));

  seq_state_t            st_q, st_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  wrap_d;
  logic                  advance;
  logic [WIDTH-1:0]      restart_val;
  logic                  terminal;

  assign restart_val = dir ? '0 : limit;
  assign terminal    = dir ? (cnt_value == limit) : (cnt_value == '0);

  // Only a command that actually acts in the current state masks the lower ones.
  always_comb begin
    st_d         = st_q;
    presc_d      = presc_q;
    wrap_d       = 1'b0;
    advance      = 1'b0;
    cnt_en       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = restart_val;
    if (load_p) begin
      cnt_load     = 1'b1;
      cnt_load_val = load_value;
      st_d         = ST_IDLE;
      presc_d      = '0;
    end else if (stop_p && (st_q == ST_RUN || st_q == ST_PAUSE)) begin
      if (st_q == ST_RUN) begin
        st_d = ST_PAUSE;
      end else begin
        st_d    = ST_IDLE;
        presc_d = '0;
      end
    end else if (start_p && st_q != ST_RUN) begin
      st_d = ST_RUN;
      if (st_q != ST_PAUSE) presc_d = '0;
      if (st_q == ST_DONE) cnt_load = 1'b1;
    end else if (step_p && (st_q == ST_IDLE || st_q == ST_PAUSE)) begin
      advance = 1'b1;
    end else if (st_q == ST_RUN) begin
      if (presc_q == prescale) begin
        presc_d = '0;
        advance = 1'b1;
      end else begin
        presc_d = presc_q + PRESCALE_W'(1);
      end
    end

    if (advance) begin
      if (!terminal) begin
        cnt_en = 1'b1;
      end else if (auto_reload) begin
        cnt_load     = 1'b1;
        cnt_load_val = restart_val;
        wrap_d       = 1'b1;
      end else begin
        st_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      presc_q <= '0;
      wrap    <= 1'b0;
    end else begin
      st_q    <= st_d;
      presc_q <= presc_d;
      wrap    <= wrap_d;
    end
  end

  assign state  = st_q;
  assign busy   = (st_q == ST_RUN);
  assign done   = (st_q == ST_DONE);
  assign cnt_up = dir;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: behavioural counter model plus a scoreboard of expected counter values.
module tb_count_sequencer;

  localparam int W  = 8;
  localparam int PW = 8;
  localparam logic [3:0] M_START = 4'b0001;
  localparam logic [3:0] M_STOP  = 4'b0010;
  localparam logic [3:0] M_STEP  = 4'b0100;
  localparam logic [3:0] M_LOAD  = 4'b1000;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, step = 1'b0, load = 1'b0;
  logic dir = 1'b1, auto_reload = 1'b0;
  logic [W-1:0]  load_value = '0, limit = '0, cnt_value;
  logic [PW-1:0] prescale = '0;
  logic cnt_en, cnt_up, cnt_load, busy, done, wrap;
  logic [W-1:0] cnt_load_val;
  logic [1:0] state;

  logic [W-1:0] cnt = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int vectors = 0, miscompares = 0, cyc = 0;
  bit sb_on = 1'b0;

  count_sequencer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .load(load),
    .dir(dir), .auto_reload(auto_reload), .load_value(load_value), .limit(limit),
    .prescale(prescale), .cnt_value(cnt_value), .cnt_en(cnt_en), .cnt_up(cnt_up),
    .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .state(state), .busy(busy),
    .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural counter driven by the sequencer strobes.
  assign cnt_value = cnt;
  always @(posedge clk) begin
    if (cnt_load) cnt <= cnt_load_val;
    else if (cnt_en) cnt <= cnt_up ? cnt + 8'd1 : cnt - 8'd1;
  end

  // Scoreboard: every counter update must match the next expected value.
  always @(negedge clk) begin
    if (sb_on && (cnt_load || cnt_en)) begin
      @(posedge clk);
      #1;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: counter moved to %0d, no update expected", cnt);
      end else begin
        exp_v = exp_q.pop_front();
        if (cnt !== exp_v) begin
          miscompares++;
          $display("FAIL sb_count: got %0d want %0d", cnt, exp_v);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pins(input logic [3:0] m);
    @(negedge clk);
    start = m[0]; stop = m[1]; step = m[2]; load = m[3];
    repeat (3) @(negedge clk);
    start = 1'b0; stop = 1'b0; step = 1'b0; load = 1'b0;
  endtask

  task automatic sb_off();
    @(posedge clk);
    #2;
    sb_on = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(1)); stop = 1'($urandom_range(1));
      step  = 1'($urandom_range(1)); load = 1'($urandom_range(1));
    end
    @(negedge clk);
    vectors++; if (state !== 2'd0)   begin miscompares++; $display("FAIL rst_state: got %0d want 0", state); end
    vectors++; if (cnt_en !== 1'b0)  begin miscompares++; $display("FAIL rst_cnt_en: got %b want 0", cnt_en); end
    vectors++; if (cnt_load !== 1'b0) begin miscompares++; $display("FAIL rst_cnt_load: got %b want 0", cnt_load); end
    vectors++; if (done !== 1'b0)    begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
    vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (wrap !== 1'b0)    begin miscompares++; $display("FAIL rst_wrap: got %b want 0", wrap); end
    dir = 1'b0; #1;
    vectors++; if (cnt_up !== 1'b0)  begin miscompares++; $display("FAIL rst_cnt_up: got %b want 0", cnt_up); end
    dir = 1'b1;
    start = 1'b0; stop = 1'b0; step = 1'b0; load = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (state !== 2'd0)   begin miscompares++; $display("FAIL rst_release_state: got %0d want 0", state); end
  endtask

  task automatic test_oneshot();
    int last, n, gap_bad, extra;
    dir = 1'b1; limit = 8'd5; prescale = 8'd3; auto_reload = 1'b0; load_value = 8'd0;
    sb_on = 1'b1;
    exp_q.push_back(8'd0);
    pins(M_LOAD);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL os_load_state: got %0d want 0", state); end
    for (int v = 1; v <= 5; v++) exp_q.push_back(8'(v));
    pins(M_START);
    last = -1; n = 0; gap_bad = 0;
    for (int i = 0; i < 100 && done !== 1'b1; i++) begin
      if (cnt_en === 1'b1) begin
        if (last >= 0 && cyc - last != 4) gap_bad++;
        last = cyc; n++;
      end
      @(negedge clk);
    end
    vectors++; if (done !== 1'b1)  begin miscompares++; $display("FAIL os_done: got %b want 1", done); end
    vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL os_state: got %0d want 3", state); end
    vectors++; if (n != 5)         begin miscompares++; $display("FAIL os_en_count: got %0d want 5", n); end
    vectors++; if (gap_bad != 0)   begin miscompares++; $display("FAIL os_en_period: got %0d bad gaps want 0", gap_bad); end
    extra = 0;
    repeat (8) begin @(negedge clk); if (cnt_en === 1'b1) extra++; end
    vectors++; if (extra != 0)     begin miscompares++; $display("FAIL os_en_after_done: got %0d want 0", extra); end
    vectors++; if (cnt !== 8'd5)   begin miscompares++; $display("FAIL os_final: got %0d want 5", cnt); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL os_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_autoreload();
    int wraps, bad_state, bad_wrap;
    dir = 1'b1; limit = 8'd2; prescale = 8'd0; auto_reload = 1'b1; load_value = 8'd0;
    exp_q.push_back(8'd0);
    pins(M_LOAD);
    for (int k = 0; k < 12; k++) exp_q.push_back(8'((k + 1) % 3));
    pins(M_START);
    wraps = 0; bad_state = 0; bad_wrap = 0;
    for (int i = 0; i < 60 && exp_q.size() > 4; i++) begin
      @(negedge clk);
      if (state !== 2'd1) bad_state++;
      if (wrap === 1'b1) begin
        wraps++;
        if (cnt !== 8'd0) bad_wrap++;
      end
    end
    vectors++; if (exp_q.size() != 4) begin miscompares++; $display("FAIL ar_progress: got %0d pending want 4", exp_q.size()); end
    vectors++; if (wraps != 2)     begin miscompares++; $display("FAIL ar_wraps: got %0d want 2", wraps); end
    vectors++; if (bad_wrap != 0)  begin miscompares++; $display("FAIL ar_wrap_value: got %0d bad want 0", bad_wrap); end
    vectors++; if (bad_state != 0) begin miscompares++; $display("FAIL ar_state_run: got %0d bad cycles want 0", bad_state); end
    sb_off();
    pins(M_STOP);
    vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL ar_pause: got %0d want 2", state); end
    pins(M_STOP);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL ar_idle: got %0d want 0", state); end
  endtask

  task automatic test_step_down();
    dir = 1'b0; auto_reload = 1'b0; limit = 8'd9; load_value = 8'd3;
    sb_on = 1'b1;
    exp_q.push_back(8'd3);
    pins(M_LOAD);
    exp_q.push_back(8'd2); exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    for (int k = 0; k < 3; k++) begin
      pins(M_STEP);
      vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL sd_state_%0d: got %0d want 0", k, state); end
    end
    pins(M_STEP);
    vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL sd_done_state: got %0d want 3", state); end
    vectors++; if (done !== 1'b1)  begin miscompares++; $display("FAIL sd_done: got %b want 1", done); end
    repeat (2) @(negedge clk);
    vectors++; if (cnt !== 8'd0)   begin miscompares++; $display("FAIL sd_final: got %0d want 0", cnt); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL sd_drain: got %0d pending want 0", exp_q.size()); end
    sb_off();
  endtask

  task automatic test_stop_start();
    int c, s, r, t;
    logic [W-1:0] held;
    dir = 1'b1; limit = 8'd200; prescale = 8'd7; auto_reload = 1'b0; load_value = 8'd0;
    pins(M_LOAD);
    pins(M_START);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      if (cnt_en === 1'b1) begin c = cyc; break; end
      @(negedge clk);
    end
    vectors++; if (c < 0) begin miscompares++; $display("FAIL ss_first_tick: no cnt_en within 40 cycles"); end
    pins(M_STOP | M_START);
    s = cyc;
    vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL ss_pause: got %0d want 2", state); end
    held = cnt;
    repeat (6) @(negedge clk);
    vectors++; if (cnt !== held)   begin miscompares++; $display("FAIL ss_hold_count: got %0d want %0d", cnt, held); end
    pins(M_START);
    r = cyc;
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL ss_resume: got %0d want 1", state); end
    t = -1;
    for (int i = 0; i < 40; i++) begin
      if (cnt_en === 1'b1) begin t = cyc; break; end
      @(negedge clk);
    end
    vectors++; if (t - r != 9 - (s - c)) begin miscompares++; $display("FAIL ss_presc_held: got %0d cycles want %0d", t - r, 9 - (s - c)); end
    pins(M_STOP);
    vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL ss_pause2: got %0d want 2", state); end
    pins(M_STOP);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL ss_idle: got %0d want 0", state); end
    pins(M_START);
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL ss_restart: got %0d want 1", state); end
  endtask

  task automatic test_load_tick();
    dir = 1'b1; limit = 8'd200; prescale = 8'd0; auto_reload = 1'b0; load_value = 8'd10;
    pins(M_LOAD);
    pins(M_START);
    load_value = 8'd77;
    @(negedge clk); load = 1'b1;
    @(negedge clk);
    vectors++; if (cnt_en !== 1'b1)     begin miscompares++; $display("FAIL lt_tick: got %b want 1", cnt_en); end
    @(negedge clk);
    vectors++; if (cnt_load !== 1'b1)   begin miscompares++; $display("FAIL lt_cnt_load: got %b want 1", cnt_load); end
    vectors++; if (cnt_load_val !== 8'd77) begin miscompares++; $display("FAIL lt_load_val: got %0d want 77", cnt_load_val); end
    vectors++; if (cnt_en !== 1'b0)     begin miscompares++; $display("FAIL lt_en_masked: got %b want 0", cnt_en); end
    @(negedge clk);
    vectors++; if (state !== 2'd0)      begin miscompares++; $display("FAIL lt_state: got %0d want 0", state); end
    vectors++; if (cnt !== 8'd77)       begin miscompares++; $display("FAIL lt_count: got %0d want 77", cnt); end
    load = 1'b0;
    limit = 8'd80;
    pins(M_START);
    for (int i = 0; i < 30 && done !== 1'b1; i++) @(negedge clk);
    vectors++; if (done !== 1'b1)       begin miscompares++; $display("FAIL lt_reach_done: got %b want 1", done); end
    vectors++; if (cnt !== 8'd80)       begin miscompares++; $display("FAIL lt_done_count: got %0d want 80", cnt); end
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (cnt_load !== 1'b1)   begin miscompares++; $display("FAIL dr_cnt_load: got %b want 1", cnt_load); end
    vectors++; if (cnt_load_val !== 8'd0) begin miscompares++; $display("FAIL dr_load_val: got %0d want 0", cnt_load_val); end
    @(negedge clk);
    vectors++; if (state !== 2'd1)      begin miscompares++; $display("FAIL dr_state: got %0d want 1", state); end
    vectors++; if (cnt !== 8'd0)        begin miscompares++; $display("FAIL dr_count: got %0d want 0", cnt); end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    vectors++; if (cnt_en !== 1'b1)   begin miscompares++; $display("FAIL rm_running: got %b want 1", cnt_en); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (cnt_en !== 1'b0)   begin miscompares++; $display("FAIL rm_cnt_en: got %b want 0", cnt_en); end
    vectors++; if (cnt_load !== 1'b0) begin miscompares++; $display("FAIL rm_cnt_load: got %b want 0", cnt_load); end
    vectors++; if (state !== 2'd0)    begin miscompares++; $display("FAIL rm_state: got %0d want 0", state); end
    vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL rm_busy: got %b want 0", busy); end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (state !== 2'd0)    begin miscompares++; $display("FAIL rm_after_state: got %0d want 0", state); end
    vectors++; if (cnt_en !== 1'b0)   begin miscompares++; $display("FAIL rm_after_en: got %b want 0", cnt_en); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_step_down();
    test_stop_start();
    test_load_tick();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
